// File: rtl/ps2_key_controller.sv
// ps2_key_controller
// Turns PS/2 set-2 scan codes into a 16-bit active-low button word.
// It also exposes that word through a latch/shift serial register, which
// behaves like a console controller shift register.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   key_byte     scan-code byte, qualified by key_valid
//   key_valid    one-cycle strobe for key_byte
//   latch        level; while high, the shift register reloads from buttons every cycle
//   shift_pulse  one-cycle strobe; shifts the register right and fills with 1
//   buttons      live button state, 0 = pressed
//   serial_out   shift register bit 0
//   frame_err    one-cycle pulse after a malformed break sequence
module ps2_key_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  key_byte,
  input  logic        key_valid,
  input  logic        latch,
  input  logic        shift_pulse,
  output logic [15:0] buttons,
  output logic        serial_out,
  output logic        frame_err
);

  localparam int unsigned BTN_W = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [BTN_W-1:0]   r_buttons;
  logic [BTN_W-1:0]   w_buttons_next;
  logic [BTN_W-1:0]   r_shift;
  logic               r_frame_err;
  logic               w_frame_err_next;
  logic               w_map_hit;
  logic [IDX_W-1:0]   w_map_idx;
  logic [BTN_W-1:0]   w_key_mask;

  // Scan code to button bit index.
  always_comb begin
    w_map_hit = 1'b1;
    w_map_idx = IDX_W'(0);
    case (key_byte)
      8'h2D:   w_map_idx = IDX_W'(0);
      8'h2C:   w_map_idx = IDX_W'(2);
      8'h2B:   w_map_idx = IDX_W'(3);
      8'h1D:   w_map_idx = IDX_W'(4);
      8'h1B:   w_map_idx = IDX_W'(5);
      8'h1C:   w_map_idx = IDX_W'(6);
      8'h23:   w_map_idx = IDX_W'(7);
      8'h24:   w_map_idx = IDX_W'(8);
      default: w_map_hit = 1'b0;
    endcase
  end

  assign w_key_mask = BTN_W'(1) << w_map_idx;

  // Parser state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Parser next-state, next button word and error strobe.
  always_comb begin
    w_state_next     = r_state;
    w_buttons_next   = r_buttons;
    w_frame_err_next = 1'b0;
    if (key_valid) begin
      case (r_state)
        IDLE: begin
          if (key_byte == 8'hF0) begin
            w_state_next = BRK;
          end else if (key_byte == 8'hE0) begin
            w_state_next = EXT;
          end else if (key_byte == 8'hAA || key_byte == 8'hFC) begin
            // Keyboard self-test result: forget every held key.
            w_buttons_next = {BTN_W{1'b1}};
          end else if (w_map_hit) begin
            w_buttons_next = r_buttons & ~w_key_mask;
          end
        end
        BRK: begin
          w_state_next = IDLE;
          if (key_byte == 8'hF0 || key_byte == 8'hE0) begin
            w_frame_err_next = 1'b1;
          end else if (w_map_hit) begin
            w_buttons_next = r_buttons | w_key_mask;
          end
        end
        EXT: begin
          // Extended keys are unmapped. Only track the break prefix.
          w_state_next = (key_byte == 8'hF0) ? EXT_BRK : IDLE;
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // Button word and error strobe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buttons   <= {BTN_W{1'b1}};
      r_frame_err <= 1'b0;
    end else begin
      r_buttons   <= w_buttons_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  // Serial snapshot register. Latch sees the same-cycle key update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= {BTN_W{1'b1}};
    end else if (latch) begin
      r_shift <= w_buttons_next;
    end else if (shift_pulse) begin
      r_shift <= {1'b1, r_shift[BTN_W-1:1]};
    end
  end

  assign buttons    = r_buttons;
  assign serial_out = r_shift[0];
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_key_controller.sv
// Directed testbench for ps2_key_controller.
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_ps2_key_controller;

  logic        clk;
  logic        reset;
  logic [7:0]  key_byte;
  logic        key_valid;
  logic        latch;
  logic        shift_pulse;
  logic [15:0] buttons;
  logic        serial_out;
  logic        frame_err;

  int n_pass;
  int n_chk;
  int n_fail;

  ps2_key_controller dut (
    .clk         (clk),
    .reset       (reset),
    .key_byte    (key_byte),
    .key_valid   (key_valid),
    .latch       (latch),
    .shift_pulse (shift_pulse),
    .buttons     (buttons),
    .serial_out  (serial_out),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Present one byte for one cycle. On return, the edge that consumed it has passed.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    key_byte  = b;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_latch();
    @(negedge clk);
    latch = 1'b1;
    @(negedge clk);
    latch = 1'b0;
  endtask

  task automatic pulse_shift();
    @(negedge clk);
    shift_pulse = 1'b1;
    @(negedge clk);
    shift_pulse = 1'b0;
  endtask

  logic [15:0] model_sr;

  initial begin
    n_pass = 0; n_chk = 0; n_fail = 0;
    reset = 1'b1; key_byte = 8'h00; key_valid = 1'b0; latch = 1'b0; shift_pulse = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk16("rst_buttons", buttons, 16'hFFFF);
    chk1("rst_serial", serial_out, 1'b1);
    chk1("rst_ferr", frame_err, 1'b0);

    // Make and break of up; typematic; break of an unpressed key
    send(8'h1D);
    chk16("make_up", buttons, 16'hFFEF);
    send(8'h1D);
    chk16("typematic_up", buttons, 16'hFFEF);
    send(8'hF0);
    chk16("break_prefix_nochg", buttons, 16'hFFEF);
    send(8'h1D);
    chk16("break_up", buttons, 16'hFFFF);
    send(8'hF0); send(8'h1B);
    chk16("break_unpressed", buttons, 16'hFFFF);

    // A and B held, then latch and shift out
    send(8'h24); send(8'h2D);
    chk16("make_A_B", buttons, 16'hFEFE);
    pulse_latch();
    model_sr = 16'hFEFE;
    chk1("sr_bit0", serial_out, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      pulse_shift();
      model_sr = {1'b1, model_sr[15:1]};
      chk1($sformatf("sr_shift%0d", i), serial_out, model_sr[0]);
    end
    chk1("sr_after17", serial_out, 1'b1);

    // Extended keys are ignored and raise no error
    do_reset();
    chk16("rst2_buttons", buttons, 16'hFFFF);
    send(8'hE0); chk1("ext_ferr0", frame_err, 1'b0);
    send(8'h1C); chk16("ext_left_make", buttons, 16'hFFFF);
    send(8'hE0); send(8'hF0); chk1("extbrk_ferr0", frame_err, 1'b0);
    send(8'h1C); chk16("ext_left_break", buttons, 16'hFFFF);
    chk1("ext_ferr_end", frame_err, 1'b0);

    // Double break prefix produces a frame error pulse
    send(8'hF0); send(8'hF0);
    chk1("ferr_pulse", frame_err, 1'b1);
    @(negedge clk);
    chk1("ferr_one_cycle", frame_err, 1'b0);
    send(8'h23);
    chk16("make_right_after_err", buttons, 16'hFF7F);
    send(8'hF0); send(8'hE0);
    chk1("ferr_e0_in_brk", frame_err, 1'b1);
    chk16("ferr_buttons_kept", buttons, 16'hFF7F);

    // Self-test response clears held keys
    send(8'h1B); send(8'h2C);
    chk16("make_down_start", buttons, 16'hFF5B);
    send(8'hAA);
    chk16("selftest_clear", buttons, 16'hFFFF);
    send(8'h2B); send(8'hFC);
    chk16("selftest_fc_clear", buttons, 16'hFFFF);

    // Reset discards a pending break
    send(8'hF0);
    do_reset();
    send(8'h2B);
    chk16("reset_drops_break", buttons, 16'hFFF7);

    // Reset wins over a same-cycle key, latch and shift
    @(negedge clk);
    reset = 1'b1; key_byte = 8'h1D; key_valid = 1'b1; latch = 1'b1; shift_pulse = 1'b1;
    @(negedge clk);
    reset = 1'b0; key_valid = 1'b0; latch = 1'b0; shift_pulse = 1'b0;
    chk16("reset_priority_btn", buttons, 16'hFFFF);
    chk1("reset_priority_sr", serial_out, 1'b1);

    // Latch captures the same-cycle make result
    @(negedge clk);
    key_byte = 8'h2D; key_valid = 1'b1; latch = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; latch = 1'b0;
    chk1("latch_same_cycle_make", serial_out, 1'b0);

    // Latch held high ignores shift_pulse
    @(negedge clk);
    latch = 1'b1; shift_pulse = 1'b1;
    @(negedge clk);
    latch = 1'b0; shift_pulse = 1'b0;
    chk1("latch_blocks_shift", serial_out, 1'b0);

    // A key byte and a shift pulse in the same cycle both take effect
    send(8'hF0);
    @(negedge clk);
    key_byte = 8'h2D; key_valid = 1'b1; shift_pulse = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; shift_pulse = 1'b0;
    chk16("simul_break", buttons, 16'hFFFF);
    chk1("simul_shift", serial_out, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
